// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave that captures a 32-bit word from fabric user logic for the PowerPC to read back,
// with freshness/overrun status and a small control register (clear, freeze).
module opb_register_simulink2ppc_snap #(
  parameter logic [31:0] C_BASEADDR   = 32'h0100C100,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100C1FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic                    Sl_xferAck,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  input  logic [31:0]             user_data_in,
  input  logic                    user_valid
);

  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_data;
  logic [15:0] r_count;
  logic        r_fresh;
  logic        r_overrun;
  logic        r_freeze;

  logic [31:0] w_wdata;
  logic [1:0]  w_word;
  logic        w_inRange;
  logic        w_ack;
  logic        w_dataReadAck;
  logic        w_ctrlWrite;
  logic        w_clear;
  logic        w_capture;
  logic        w_overrunSet;
  logic [31:0] w_readMux;
  logic        w_unused;

  assign w_wdata   = OPB_DBus;
  assign w_word    = OPB_ABus[28:29];
  assign w_inRange = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign w_ack     = (r_state == ACK);

  assign w_dataReadAck = w_ack && OPB_RNW && (w_word == 2'd0);
  assign w_ctrlWrite   = w_ack && !OPB_RNW && (w_word == 2'd2) && OPB_BE[3];
  assign w_clear       = w_ctrlWrite && w_wdata[0];
  assign w_capture     = user_valid && !r_freeze;
  // A read of DATA in the same cycle consumes the old word, so it is not an overrun.
  assign w_overrunSet  = w_capture && r_fresh && !w_dataReadAck;

  assign w_unused = ^{1'b0, OPB_seqAddr, OPB_BE[0:2], w_wdata[31:2], C_FAMILY};

  always_comb begin
    w_readMux = 32'h0;
    case (w_word)
      2'd0:    w_readMux = r_data;
      2'd1:    w_readMux = {r_count, 14'h0, r_overrun, r_fresh};
      2'd2:    w_readMux = {30'h0, r_freeze, 1'b0};
      default: w_readMux = 32'h0;
    endcase
  end

  assign Sl_xferAck = w_ack;
  assign Sl_DBus    = (w_ack && OPB_RNW) ? w_readMux : 32'h0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // WAIT holds off a second ack until the master drops select.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (OPB_select && w_inRange) w_nextState = ACK;
      ACK:     w_nextState = WAIT;
      WAIT:    if (!OPB_select) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      r_data    <= 32'h0;
      r_count   <= 16'h0;
      r_fresh   <= 1'b0;
      r_overrun <= 1'b0;
      r_freeze  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_data  <= user_data_in;
        r_fresh <= 1'b1;
      end else if (w_dataReadAck) begin
        r_fresh <= 1'b0;
      end
      // Capture increment wins over a simultaneous clear, leaving a count of one.
      if (w_capture)    r_count <= w_clear ? 16'd1 : r_count + 16'd1;
      else if (w_clear) r_count <= 16'd0;
      if (w_overrunSet) r_overrun <= 1'b1;
      else if (w_clear) r_overrun <= 1'b0;
      if (w_ctrlWrite)  r_freeze <= w_wdata[1];
    end
  end

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Self-checking bench: a transaction-level model of the register window is compared against the
// DUT bus outputs every cycle, and directed reads are checked against hand-computed values.
module tb_opb_register_simulink2ppc_snap;

  localparam logic [31:0] BASE = 32'h0100C100;
  localparam logic [31:0] HIGH = 32'h0100C1FF;
  localparam logic [31:0] A_DATA = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;
  localparam logic [31:0] A_RSVD = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dbusOut;
  logic        errAck, retry, toutSup, ack;
  logic [31:0] abus = 32'h0;
  logic [3:0]  be = 4'h0;
  logic [31:0] dbusIn = 32'h0;
  logic        rnw = 1'b0;
  logic        sel = 1'b0;
  logic        seqAddr = 1'b0;
  logic [31:0] ud = 32'h0;
  logic        uv = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  opb_register_simulink2ppc_snap dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .Sl_DBus(dbusOut), .Sl_errAck(errAck),
    .Sl_retry(retry), .Sl_toutSup(toutSup), .Sl_xferAck(ack), .OPB_ABus(abus),
    .OPB_BE(be), .OPB_DBus(dbusIn), .OPB_RNW(rnw), .OPB_select(sel),
    .OPB_seqAddr(seqAddr), .user_data_in(ud), .user_valid(uv)
  );

  // Model state: one outstanding ack per select period, register contents as plain values.
  logic        mAck, mServed, mFresh, mOver, mFreeze;
  logic [31:0] mData;
  int          mCount;

  wire [31:0] mOffset  = abus - BASE;
  wire [1:0]  mWord    = mOffset[3:2];
  wire        mInRange = sel && (abus >= BASE) && (abus <= HIGH);
  wire        mCap     = uv && !mFreeze;
  wire        mDataRd  = mAck && rnw && (mWord == 2'd0);
  wire        mCtrlWr  = mAck && !rnw && (mWord == 2'd2) && be[0];
  wire        mClr     = mCtrlWr && dbusIn[0];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mAck <= 1'b0; mServed <= 1'b0; mData <= 32'h0; mCount <= 0;
      mFresh <= 1'b0; mOver <= 1'b0; mFreeze <= 1'b0;
    end else begin
      mAck    <= mInRange && !mServed;
      mServed <= mAck || (mServed ? sel : mInRange);
      if (mCap) begin mData <= ud; mFresh <= 1'b1; end
      else if (mDataRd) mFresh <= 1'b0;
      if (mCap) mCount <= mClr ? 1 : (mCount + 1) % 65536;
      else if (mClr) mCount <= 0;
      if (mCap && mFresh && !mDataRd) mOver <= 1'b1;
      else if (mClr) mOver <= 1'b0;
      if (mCtrlWr) mFreeze <= dbusIn[1];
    end
  end

  function automatic logic [31:0] modelRead(input logic [1:0] word);
    logic [31:0] cnt;
    cnt = mCount;
    case (word)
      2'd0:    return mData;
      2'd1:    return {cnt[15:0], 14'h0, mOver, mFresh};
      2'd2:    return {30'h0, mFreeze, 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle: ack and read bus must match the model; tied outputs stay low.
  always @(negedge clk) begin
    checkOutput("cycleAck", {31'h0, ack}, {31'h0, mAck});
    checkOutput("cycleDBus", dbusOut, (mAck && rnw) ? modelRead(mWord) : 32'h0);
    checkOutput("cycleTied", {29'h0, errAck, retry, toutSup}, 32'h0);
  end

  // One bus transfer with select held five cycles; optional capture in the ack cycle.
  task automatic applyStimulus(input string name, input logic isRead, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [3:0] bEn, input logic cap,
                               input logic [31:0] capWord, input int expAcks,
                               output logic [31:0] rd);
    int lat;
    int ackCount;
    @(posedge clk); #1;
    sel = 1'b1; rnw = isRead; abus = addr; dbusIn = wd; be = bEn;
    lat = -1; ackCount = 0; rd = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        ackCount++;
        if (lat < 0) begin
          lat = i; rd = dbusOut;
          if (cap) begin
            uv = 1'b1; ud = capWord;
            @(posedge clk); #1;
            uv = 1'b0;
          end
        end
      end
    end
    @(posedge clk); #1;
    sel = 1'b0; rnw = 1'b0; abus = 32'h0; dbusIn = 32'h0; be = 4'h0;
    @(posedge clk); #1;
    checkOutput({name, " ackCount"}, ackCount, expAcks);
    if (expAcks == 1) checkOutput({name, " latency"}, lat, 32'd1);
  endtask

  task automatic readExpect(input string name, input logic [31:0] addr, input logic [31:0] expected);
    logic [31:0] rd;
    applyStimulus(name, 1'b1, addr, 32'h0, 4'h0, 1'b0, 32'h0, 1, rd);
    checkOutput(name, rd, expected);
  endtask

  task automatic writeReg(input string name, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] bEn, input logic cap, input logic [31:0] capWord);
    logic [31:0] rd;
    applyStimulus(name, 1'b0, addr, wd, bEn, cap, capWord, 1, rd);
  endtask

  task automatic capturePulse(input logic [31:0] word);
    @(posedge clk); #1;
    uv = 1'b1; ud = word;
    @(posedge clk); #1;
    uv = 1'b0;
  endtask

  initial begin
    #1_500_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetAck", {31'h0, ack}, 32'h0);
    checkOutput("resetDBus", dbusOut, 32'h0);
    rst = 1'b0;
    readExpect("resetStatus", A_STAT, 32'h00000000);

    $display("[TB] single capture");
    capturePulse(32'hDEADBEEF);
    readExpect("capStatus", A_STAT, 32'h00010001);
    readExpect("capData", A_DATA, 32'hDEADBEEF);
    readExpect("capStatusAfter", A_STAT, 32'h00010000);

    $display("[TB] overrun and clear");
    writeReg("clr0", A_CTRL, 32'h1, 4'b0001, 1'b0, 32'h0);
    readExpect("clrStatus", A_STAT, 32'h00000000);
    capturePulse(32'h1);
    capturePulse(32'h2);
    readExpect("ovrStatus", A_STAT, 32'h00020003);
    writeReg("clr1", A_CTRL, 32'h1, 4'b0001, 1'b0, 32'h0);
    readExpect("ovrCleared", A_STAT, 32'h00000001);

    $display("[TB] capture during data read");
    readExpect("drain", A_DATA, 32'h2);
    capturePulse(32'h4);
    applyStimulus("simRead", 1'b1, A_DATA, 32'h0, 4'h0, 1'b1, 32'h5, 1, rd);
    checkOutput("simReadOld", rd, 32'h4);
    readExpect("simStatus", A_STAT, 32'h00020001);
    readExpect("simData", A_DATA, 32'h5);
    readExpect("simStatusAfter", A_STAT, 32'h00020000);

    $display("[TB] capture during clear");
    capturePulse(32'h6);
    writeReg("clrCap", A_CTRL, 32'h1, 4'b0001, 1'b1, 32'h7);
    readExpect("clrCapStatus", A_STAT, 32'h00010003);

    $display("[TB] freeze");
    writeReg("frzOn", A_CTRL, 32'h2, 4'b0001, 1'b1, 32'h8);
    readExpect("frzCtrl", A_CTRL, 32'h00000002);
    capturePulse(32'h9);
    capturePulse(32'hA);
    capturePulse(32'hB);
    readExpect("frzStatus", A_STAT, 32'h00020003);
    readExpect("frzData", A_DATA, 32'h8);
    readExpect("frzStatusAfter", A_STAT, 32'h00020002);
    writeReg("beMasked", A_CTRL, 32'h0, 4'b1110, 1'b0, 32'h0);
    readExpect("beMaskedCtrl", A_CTRL, 32'h00000002);
    writeReg("frzOff", A_CTRL, 32'h1, 4'b0001, 1'b0, 32'h0);
    readExpect("frzOffStatus", A_STAT, 32'h00000000);

    $display("[TB] count wrap");
    @(posedge clk); #1;
    uv = 1'b1; ud = 32'h12345678;
    repeat (65536) @(posedge clk);
    #1;
    uv = 1'b0;
    readExpect("wrapStatus", A_STAT, 32'h00000003);
    readExpect("wrapData", A_DATA, 32'h12345678);

    $display("[TB] ignored writes, reserved, range");
    writeReg("dataWrite", A_DATA, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0);
    readExpect("dataWriteIgnored", A_DATA, 32'h12345678);
    readExpect("reserved", A_RSVD, 32'h00000000);
    applyStimulus("aboveRange", 1'b1, 32'h0100C200, 32'h0, 4'h0, 1'b0, 32'h0, 0, rd);
    applyStimulus("belowRange", 1'b1, 32'h0100C0FC, 32'h0, 4'h0, 1'b0, 32'h0, 0, rd);

    $display("[TB] reset during ack");
    @(posedge clk); #1;
    sel = 1'b1; rnw = 1'b1; abus = A_STAT;
    @(posedge clk); #1;
    checkOutput("ackBeforeReset", {31'h0, ack}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("ackInReset", {31'h0, ack}, 32'h0);
    checkOutput("dbusInReset", dbusOut, 32'h0);
    @(posedge clk); #1;
    sel = 1'b0; rnw = 1'b0; abus = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    readExpect("statusAfterReset", A_STAT, 32'h00000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
